// File: rtl/maxflow_l1_responder.sv
// Slave end of the task-worker l1 port: one AXI-style transaction at a time over a DEPTH_WORDS x 64 synchronous RAM.
// Define MAXFLOW_L1_RESP_ERR_EN to answer SLVERR for addresses beyond the RAM instead of wrapping them.
module maxflow_l1_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_axi_l1_ARVALID,
  output logic        s_axi_l1_ARREADY,
  input  logic [31:0] s_axi_l1_ARADDR,
  input  logic [7:0]  s_axi_l1_ARLEN,
  input  logic [2:0]  s_axi_l1_ARSIZE,
  output logic        s_axi_l1_RVALID,
  input  logic        s_axi_l1_RREADY,
  output logic [63:0] s_axi_l1_RDATA,
  output logic        s_axi_l1_RLAST,
  output logic        s_axi_l1_RID,
  output logic [1:0]  s_axi_l1_RRESP,
  input  logic        s_axi_l1_AWVALID,
  output logic        s_axi_l1_AWREADY,
  input  logic [31:0] s_axi_l1_AWADDR,
  input  logic [7:0]  s_axi_l1_AWLEN,
  input  logic [2:0]  s_axi_l1_AWSIZE,
  input  logic        s_axi_l1_WVALID,
  output logic        s_axi_l1_WREADY,
  input  logic [31:0] s_axi_l1_WDATA,
  input  logic [3:0]  s_axi_l1_WSTRB,
  input  logic        s_axi_l1_WLAST,
  output logic        s_axi_l1_BVALID,
  input  logic        s_axi_l1_BREADY,
  output logic [1:0]  s_axi_l1_BRESP,
  output logic        s_axi_l1_BID
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR_RESP} state_t;

  state_t        state, state_nx;
  logic [31:0]   rd_addr;
  logic [7:0]    rd_len;
  logic [7:0]    beat;
  logic          rd_is32;
  logic          b_err;
  logic [63:0]   mem [DEPTH_WORDS];
  logic [63:0]   ram_q;
  logic [31:0]   rd_lane;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          rd_oob;
  logic          wr_oob;
  logic          wr_go;
  logic          ar_hs;
  logic          wr_hs;
  logic          r_hs;
  logic          last_beat;
  logic          unused_ok;

  assign rd_idx    = rd_addr[AW+2:3];
  assign wr_idx    = s_axi_l1_AWADDR[AW+2:3];
  assign last_beat = (beat == rd_len);

`ifdef MAXFLOW_L1_RESP_ERR_EN
  assign rd_oob = |rd_addr[31:AW+3];
  assign wr_oob = |s_axi_l1_AWADDR[31:AW+3];
`else
  assign rd_oob = 1'b0;
  assign wr_oob = 1'b0;
`endif

  // A pending read always wins the IDLE cycle; the write is only taken with both AW and W present.
  assign wr_go = s_axi_l1_AWVALID && s_axi_l1_WVALID && !s_axi_l1_ARVALID;
  assign ar_hs = (state == IDLE) && s_axi_l1_ARVALID;
  assign wr_hs = (state == IDLE) && wr_go;
  assign r_hs  = (state == RD_DATA) && s_axi_l1_RREADY;

  // Every write is a single 32-bit beat, so burst shape fields carry no information.
  assign unused_ok = ^{s_axi_l1_AWLEN, s_axi_l1_AWSIZE, s_axi_l1_WLAST, s_axi_l1_AWADDR};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (s_axi_l1_ARVALID) state_nx = RD_ADDR;
        else if (wr_go)       state_nx = WR_RESP;
      end
      RD_ADDR: state_nx = RD_DATA;
      RD_DATA: if (s_axi_l1_RREADY) state_nx = last_beat ? IDLE : RD_ADDR;
      WR_RESP: if (s_axi_l1_BREADY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat  <= '0;
      b_err <= 1'b0;
    end else begin
      if (ar_hs) begin
        rd_addr <= s_axi_l1_ARADDR;
        rd_len  <= s_axi_l1_ARLEN;
        rd_is32 <= (s_axi_l1_ARSIZE == 3'b010);
        beat    <= '0;
      end else if (r_hs && !last_beat) begin
        rd_addr <= rd_addr + (rd_is32 ? 32'd4 : 32'd8);
        beat    <= beat + 8'd1;
      end
      if (wr_hs) b_err <= wr_oob;
    end
  end

  // NOTE: the RAM array has no reset; its contents must survive rstn, and a reset would also block RAM inference.
  always_ff @(posedge clk) begin
    if (rstn && wr_hs && !wr_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_l1_WSTRB[b])
          mem[wr_idx][{s_axi_l1_AWADDR[2], b[1:0], 3'b000} +: 8] <= s_axi_l1_WDATA[b*8 +: 8];
      end
    end
    if (state == RD_ADDR) ram_q <= mem[rd_idx];
  end

  always_comb begin
    // NOTE: every output gets a default first so no state leaves a path unassigned and infers a latch.
    s_axi_l1_ARREADY = 1'b0;
    s_axi_l1_AWREADY = 1'b0;
    s_axi_l1_WREADY  = 1'b0;
    s_axi_l1_RVALID  = 1'b0;
    s_axi_l1_RLAST   = 1'b0;
    s_axi_l1_BVALID  = 1'b0;
    case (state)
      IDLE: begin
        s_axi_l1_ARREADY = 1'b1;
        s_axi_l1_AWREADY = wr_go;
        s_axi_l1_WREADY  = wr_go;
      end
      RD_DATA: begin
        s_axi_l1_RVALID = 1'b1;
        s_axi_l1_RLAST  = last_beat;
      end
      WR_RESP: s_axi_l1_BVALID = 1'b1;
      default: ;
    endcase
  end

  // A 32-bit beat mirrors its lane into both halves so either half of RDATA is usable.
  assign rd_lane        = rd_addr[2] ? ram_q[63:32] : ram_q[31:0];
  assign s_axi_l1_RDATA = rd_oob ? 64'd0 : (rd_is32 ? {rd_lane, rd_lane} : ram_q);
  assign s_axi_l1_RRESP = rd_oob ? 2'b10 : 2'b00;
  assign s_axi_l1_RID   = 1'b0;
  assign s_axi_l1_BRESP = b_err ? 2'b10 : 2'b00;
  assign s_axi_l1_BID   = 1'b0;

endmodule

// File: doc/maxflow_l1_responder.md
MAXFLOW_L1_RESPONDER -- requirements
Module: maxflow_l1_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 64-bit RAM words, power of two.
REQ-002 SHALL have ports clk (in, 1, clock) and rstn (in, 1, reset: synchronous, active-low).
REQ-003 SHALL have s_axi_l1_ARVALID in 1, ARREADY out 1, ARADDR in 32, ARLEN in 8, ARSIZE in 3: read address channel.
REQ-004 SHALL have s_axi_l1_RVALID out 1, RREADY in 1, RDATA out 64, RLAST out 1, RID out 1, RRESP out 2: read data channel.
REQ-005 SHALL have s_axi_l1_AWVALID in 1, AWREADY out 1, AWADDR in 32, AWLEN in 8, AWSIZE in 3: write address channel.
REQ-006 SHALL have s_axi_l1_WVALID in 1, WREADY out 1, WDATA in 32, WSTRB in 4, WLAST in 1: write data channel.
REQ-007 SHALL have s_axi_l1_BVALID out 1, BREADY in 1, BRESP out 2, BID out 1: write response channel.

Function
REQ-008 SHALL be the slave end of the task-worker l1 port, backed by a DEPTH_WORDS x 64 synchronous RAM with 1-cycle read latency.
REQ-009 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_RESP; only one transaction SHALL be in flight at a time.
REQ-010 SHALL assert ARREADY only in IDLE.
REQ-011 SHALL assert AWREADY and WREADY together, only in IDLE, only when AWVALID & WVALID & !ARVALID.
REQ-012 SHALL give AR priority when AR and AW/W are valid in the same IDLE cycle; the write SHALL wait.
REQ-013 SHALL on AR handshake latch address, ARLEN and ARSIZE, set a beat counter to 0 and go to RD_ADDR.
REQ-014 SHALL in RD_ADDR issue a RAM read of word ARADDR[31:3] mod DEPTH_WORDS, then go to RD_DATA.
REQ-015 SHALL in RD_DATA hold RVALID=1 and stable RDATA/RLAST/RRESP until RREADY.
REQ-016 SHALL on an RD_DATA handshake go to IDLE if RLAST, else to RD_ADDR with address += (1 << ARSIZE) and beat counter incremented.
REQ-017 SHALL give first-beat RVALID exactly 2 cycles after the AR handshake edge; steady throughput is one beat per 2 cycles with RREADY held high.
REQ-018 SHALL assert RLAST when the beat counter equals the latched ARLEN; ARLEN 0..255 (INCR burst) SHALL be supported.
REQ-019 SHALL for ARSIZE=3'b011 drive RDATA with the full 64-bit word.
REQ-020 SHALL for ARSIZE=3'b010 drive RDATA = {lane, lane}, where lane is bits [63:32] if addr[2] else [31:0]; the value is thus valid in either half.
REQ-021 SHALL treat any other ARSIZE as 3'b011.
REQ-022 SHALL on a write handshake write WDATA into lane addr[2] of word AWADDR[31:3] mod DEPTH_WORDS under WSTRB; bytes with strobe 0 SHALL be unchanged.
REQ-023 SHALL ignore AWLEN, AWSIZE and WLAST: every write is treated as a single 32-bit beat.
REQ-024 SHALL after a write go to WR_RESP with BVALID=1 the next cycle, hold it until BREADY, then return to IDLE.
REQ-025 SHALL drive RID=0, BID=0, RRESP=2'b00 and BRESP=2'b00 except as in REQ-030.
REQ-026 SHALL return new data for a read issued after a completed write (B handshake) to the same word.

Reset
REQ-027 SHALL while rstn=0 at a clk edge go to IDLE and clear the beat counter; RVALID, BVALID and RLAST SHALL be 0 from the next cycle.
REQ-028 SHALL abort any partial burst or pending B response on reset mid-operation; no further beat or response is emitted.
REQ-029 SHALL leave RAM contents unchanged by reset.

Configuration
REQ-030 SHALL with macro MAXFLOW_L1_RESP_ERR_EN defined treat addresses >= DEPTH_WORDS*8 as out of range: read beats return RDATA=0 and RRESP=2'b10, and writes are dropped with BRESP=2'b10.
REQ-031 SHALL without MAXFLOW_L1_RESP_ERR_EN wrap all addresses modulo DEPTH_WORDS*8 and always respond OKAY.

Verification
REQ-032 SHALL cover a write of 0x12345678 at 0x48 (WSTRB=4'hF) followed by a 32-bit read of 0x48: RDATA=0x12345678_12345678, RLAST=1, RRESP=0.
REQ-033 SHALL cover a 64-bit read of 0x0 with ARLEN=6: exactly 7 beats at addresses 0x0..0x30, RLAST only on beat 7, first RVALID 2 cycles after AR.
REQ-034 SHALL cover WSTRB=4'b0011 writing 0xAAAA_BBBB over 0xFFFF_FFFF: readback is 0xFFFF_BBBB.
REQ-035 SHALL cover ARVALID and AWVALID/WVALID asserted in the same cycle: the read completes first, then the write is accepted and BVALID follows.
REQ-036 SHALL cover RREADY held low for 5 cycles mid-burst: RDATA stays stable, no beat is lost or duplicated.
REQ-037 SHALL cover rstn pulsed during beat 3 of an ARLEN=7 burst: no RVALID after reset, and a new AR is accepted in IDLE.
